// File: rtl/irq_pending_ctrl.sv
// Request-capture and service controller feeding a 4-to-2 priority encoder.
// Optional per-line masking is enabled by defining IRQ_MASK_EN.
module irq_pending_ctrl #(
    parameter int unsigned HOLDOFF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    output logic [3:0] pend,
    output logic       enc_en,
    input  logic [1:0] enc_code,
    input  logic       enc_valid,
    output logic       irq,
    output logic [1:0] irq_id,
    input  logic       ack,
`ifdef IRQ_MASK_EN
    input  logic [3:0] mask,
`endif
    output logic [3:0] overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLD
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);

    state_t     state_q, state_d;
    logic [3:0] req_q;
    logic [3:0] pend_q;
    logic [3:0] cnt_q;
    logic [3:0] edge_vec;
    logic [3:0] clr_vec;
    logic       ack_acc;
    logic       grant;

    assign edge_vec = req_in & ~req_q;
    assign ack_acc  = (state_q == ST_ASSERT) && ack;
    assign grant    = (state_q == ST_IDLE) && enc_valid;
    assign clr_vec  = ack_acc ? (4'b0001 << irq_id) : 4'b0000;

`ifdef IRQ_MASK_EN
    // Masked lines keep their pending bit but are hidden from the encoder.
    assign pend = pend_q & ~mask;
`else
    assign pend = pend_q;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (enc_valid) state_d = ST_ASSERT;
            ST_ASSERT: if (ack) state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
            ST_HOLD:   if (cnt_q <= 4'd1) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs: the encoder is only enabled while idle and out of reset.
    always_comb begin
        enc_en = (state_q == ST_IDLE) && !rst;
        irq    = (state_q == ST_ASSERT);
    end

    // Capture, pending/overrun tracking, grant index and hold-off counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            // A line held high through reset must not look like a fresh edge.
            req_q   <= 4'b1111;
            pend_q  <= 4'b0000;
            overrun <= 4'b0000;
            irq_id  <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            req_q   <= req_in;
            pend_q  <= (pend_q & ~clr_vec) | edge_vec;
            overrun <= overrun | (edge_vec & pend_q & ~clr_vec);
            if (grant) irq_id <= enc_code;
            if (ack_acc)                 cnt_q <= HOLD_INIT;
            else if (state_q == ST_HOLD) cnt_q <= cnt_q - 4'd1;
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl with a behavioural encoder and reference model.
module tb_irq_pending_ctrl;

    localparam int unsigned HOLDOFF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_in = 4'b0000;
    logic [3:0] pend;
    logic       enc_en;
    logic [1:0] enc_code;
    logic       enc_valid;
    logic       irq;
    logic [1:0] irq_id;
    logic       ack = 1'b0;
    logic [3:0] overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [3:0] m_pend, m_ovr, m_req_prev;
    logic       m_irq, m_en;
    logic [1:0] m_id;
    int         m_cyc = 0;
    int         m_ok  = 0;

    always #5 clk = ~clk;

    irq_pending_ctrl #(.HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .pend(pend), .enc_en(enc_en),
        .enc_code(enc_code), .enc_valid(enc_valid), .irq(irq), .irq_id(irq_id),
        .ack(ack), .overrun(overrun)
    );

    function automatic logic [1:0] highest(input logic [3:0] v);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    // Behavioural p_encoder: highest set bit wins.
    always_comb begin
        enc_valid = enc_en && (pend != 4'b0000);
        enc_code  = highest(pend);
    end

    // Drive one clock of inputs and advance the model; outputs sampled 1 time unit after the edge.
    task automatic step(input logic [3:0] r, input logic a, input logic rs);
        logic [3:0] e, clr;
        req_in = r; ack = a; rst = rs;
        @(posedge clk);
        m_cyc++;
        if (rs) begin
            m_pend = 0; m_ovr = 0; m_irq = 0; m_id = 0; m_req_prev = 4'hf; m_ok = 0;
        end else begin
            e = r & ~m_req_prev;
            m_req_prev = r;
            clr = 0;
            if (m_irq && a) begin
                clr = 4'b0001 << m_id;
                m_irq = 0;
                m_ok = m_cyc + HOLDOFF + 1;
            end else if (!m_irq && m_cyc >= m_ok && m_pend != 0) begin
                m_id = highest(m_pend);
                m_irq = 1;
            end
            m_ovr  = m_ovr | (e & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | e;
        end
        m_en = !rs && !m_irq && (m_cyc + 1 >= m_ok);
        #1;
    endtask

    task automatic test_reset;
        step(4'b0100, 0, 1);
        step(4'b0100, 0, 1);
        n_checks++; if (enc_en !== 1'b0) begin n_errors++; $display("FAIL rst_enc_en got=%b exp=0", enc_en); end
        step(4'b0100, 0, 0);
        n_checks++; if (pend !== 4'b0000 || irq !== 1'b0 || overrun !== 4'b0000) begin
            n_errors++; $display("FAIL reset_state pend=%b irq=%b ovr=%b exp 0000/0/0000", pend, irq, overrun); end
        step(4'b0000, 0, 0);
        step(4'b0100, 0, 0);
        n_checks++; if (pend !== 4'b0100 || irq !== 1'b0) begin
            n_errors++; $display("FAIL edge_capture pend=%b irq=%b exp 0100/0", pend, irq); end
        step(4'b0100, 0, 0);
        n_checks++; if (irq !== 1'b1 || irq_id !== 2'd2) begin
            n_errors++; $display("FAIL grant_latency irq=%b id=%0d exp 1/2", irq, irq_id); end
        step(4'b0100, 1, 0);
        n_checks++; if (irq !== 1'b0 || pend !== 4'b0000) begin
            n_errors++; $display("FAIL ack_clear irq=%b pend=%b exp 0/0000", irq, pend); end
        repeat (4) step(4'b0000, 0, 0);
    endtask

    task automatic test_priority;
        step(4'b1001, 0, 0);
        n_checks++; if (pend !== 4'b1001) begin n_errors++; $display("FAIL prio_pend got=%b exp=1001", pend); end
        step(4'b1001, 0, 0);
        n_checks++; if (irq !== 1'b1 || irq_id !== 2'd3) begin
            n_errors++; $display("FAIL prio_first irq=%b id=%0d exp 1/3", irq, irq_id); end
        step(4'b1001, 1, 0);
        n_checks++; if (pend !== 4'b0001 || irq !== 1'b0) begin
            n_errors++; $display("FAIL prio_ack pend=%b irq=%b exp 0001/0", pend, irq); end
        for (int i = 0; i < HOLDOFF; i++) begin
            step(4'b1001, 0, 0);
            n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL holdoff_low cyc=%0d irq=%b exp 0", i, irq); end
        end
        step(4'b1001, 0, 0);
        n_checks++; if (irq !== 1'b1 || irq_id !== 2'd0) begin
            n_errors++; $display("FAIL prio_second irq=%b id=%0d exp 1/0", irq, irq_id); end
        step(4'b0000, 1, 0);
        repeat (4) step(4'b0000, 0, 0);
    endtask

    task automatic test_overrun;
        step(4'b0010, 0, 0);
        step(4'b0000, 0, 0);
        step(4'b0010, 0, 0);
        n_checks++; if (overrun !== 4'b0010 || pend !== 4'b0010 || irq !== 1'b1) begin
            n_errors++; $display("FAIL overrun_set ovr=%b pend=%b irq=%b exp 0010/0010/1", overrun, pend, irq); end
        step(4'b0000, 1, 0);
        n_checks++; if (overrun !== 4'b0010 || pend !== 4'b0000) begin
            n_errors++; $display("FAIL overrun_sticky ovr=%b pend=%b exp 0010/0000", overrun, pend); end
        repeat (4) step(4'b0000, 0, 0);
    endtask

    task automatic test_set_clear;
        step(4'b0000, 0, 1);
        step(4'b0000, 0, 0);
        step(4'b0010, 0, 0);
        step(4'b0000, 0, 0);
        n_checks++; if (irq !== 1'b1 || irq_id !== 2'd1) begin
            n_errors++; $display("FAIL setclr_grant irq=%b id=%0d exp 1/1", irq, irq_id); end
        step(4'b0010, 1, 0);
        n_checks++; if (pend !== 4'b0010 || overrun !== 4'b0000 || irq !== 1'b0) begin
            n_errors++; $display("FAIL setclr_same pend=%b ovr=%b irq=%b exp 0010/0000/0", pend, overrun, irq); end
        repeat (HOLDOFF) step(4'b0010, 0, 0);
        step(4'b0010, 0, 0);
        n_checks++; if (irq !== 1'b1 || irq_id !== 2'd1) begin
            n_errors++; $display("FAIL setclr_regrant irq=%b id=%0d exp 1/1", irq, irq_id); end
        step(4'b0000, 1, 0);
        repeat (4) step(4'b0000, 0, 0);
    endtask

    task automatic test_reset_mid_and_hold_ack;
        step(4'b1010, 0, 0);
        step(4'b1010, 0, 0);
        n_checks++; if (irq !== 1'b1 || pend !== 4'b1010) begin
            n_errors++; $display("FAIL mid_pre irq=%b pend=%b exp 1/1010", irq, pend); end
        step(4'b1010, 0, 1);
        n_checks++; if (irq !== 1'b0 || pend !== 4'b0000 || irq_id !== 2'd0 || enc_en !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset irq=%b pend=%b id=%0d en=%b exp 0/0000/0/0", irq, pend, irq_id, enc_en); end
        step(4'b1010, 0, 0);
        n_checks++; if (pend !== 4'b0000 || enc_en !== 1'b1) begin
            n_errors++; $display("FAIL mid_idle pend=%b en=%b exp 0000/1", pend, enc_en); end
        step(4'b0000, 0, 0);
        step(4'b0101, 0, 0);
        step(4'b0101, 0, 0);
        step(4'b0101, 1, 0);
        step(4'b0101, 1, 0);
        n_checks++; if (pend !== 4'b0001 || irq !== 1'b0 || enc_en !== 1'b0) begin
            n_errors++; $display("FAIL hold_ack pend=%b irq=%b en=%b exp 0001/0/0", pend, irq, enc_en); end
        repeat (HOLDOFF - 1) step(4'b0101, 0, 0);
        step(4'b0101, 0, 0);
        n_checks++; if (irq !== 1'b1 || irq_id !== 2'd0) begin
            n_errors++; $display("FAIL hold_regrant irq=%b id=%0d exp 1/0", irq, irq_id); end
        step(4'b0000, 1, 0);
        repeat (4) step(4'b0000, 0, 0);
    endtask

    task automatic test_random;
        logic [3:0] r;
        logic       a, rs;
        step(4'b0000, 0, 1);
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            r  = r ^ 4'($urandom & $urandom);
            a  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 99) == 0);
            step(r, a, rs);
            n_checks++;
            if (pend !== m_pend || overrun !== m_ovr || irq !== m_irq || enc_en !== m_en ||
                (m_irq && irq_id !== m_id)) begin
                n_errors++;
                $display("FAIL random cyc=%0d pend=%b/%b ovr=%b/%b irq=%b/%b en=%b/%b id=%0d/%0d (got/exp)",
                         i, pend, m_pend, overrun, m_ovr, irq, m_irq, enc_en, m_en, irq_id, m_id);
            end
        end
    endtask

    initial begin
        m_pend = 0; m_ovr = 0; m_req_prev = 4'hf; m_irq = 0; m_id = 0; m_en = 0;
        test_reset();
        test_priority();
        test_overrun();
        test_set_clear();
        test_reset_mid_and_hold_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
